wb_timeout_reg: RTL and testbench

- Registered Wishbone slice with a bus watchdog, placed directly downstream of the multi-master arbiter and upstream of the shared slave or interconnect.
- Breaks the combinational path from arbiter to slave.
- Forwards one classic-cycle transfer at a time.
- Ends any transfer the slave fails to answer within TIMEOUT cycles by returning ERR to the granted master, so a hung slave cannot stall the arbiter forever.

---
 rtl/wb_timeout_reg.sv | 176 +++++++++++++++++
 tb/tb_wb_timeout_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_timeout_reg.sv
// Registered Wishbone classic-cycle slice with a bus watchdog that aborts hung slave
// transfers by returning ERR to the master.
module wb_timeout_reg #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT      = 256,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    timeout_cnt_o
);

    // Watchdog only needs to reach TIMEOUT-1.
    localparam int unsigned WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

    state_e                  r_state, w_state;
    logic [ADDR_WIDTH-1:0]   r_adr, w_adr;
    logic [DATA_WIDTH-1:0]   r_sdat, w_sdat;
    logic [DATA_WIDTH-1:0]   r_mdat, w_mdat;
    logic [SELECT_WIDTH-1:0] r_sel, w_sel;
    logic                    r_we, w_we;
    logic                    r_cyc, w_cyc;
    logic                    r_stb, w_stb;
    logic                    r_ack, w_ack;
    logic                    r_err, w_err;
    logic                    r_rty, w_rty;
    logic                    r_tout, w_tout;
    logic [CNT_WIDTH-1:0]    r_tcnt, w_tcnt;
    logic [WD_WIDTH-1:0]     r_wdog, w_wdog;
    logic                    w_resp;
    logic                    w_wd_hit;

    assign w_resp   = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_wd_hit = (TIMEOUT != 0) && (r_wdog == WD_WIDTH'(TIMEOUT - 1));

    always_comb begin
        w_state = r_state;
        w_adr   = r_adr;
        w_sdat  = r_sdat;
        w_mdat  = r_mdat;
        w_sel   = r_sel;
        w_we    = r_we;
        w_cyc   = r_cyc;
        w_stb   = r_stb;
        w_ack   = r_ack;
        w_err   = r_err;
        w_rty   = r_rty;
        w_tout  = r_tout;
        w_tcnt  = r_tcnt;
        w_wdog  = r_wdog;
        unique case (r_state)
            StIdle: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    w_adr   = wbm_adr_i;
                    w_sdat  = wbm_dat_i;
                    w_we    = wbm_we_i;
                    w_sel   = wbm_sel_i;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_wdog  = '0;
                    w_state = StActive;
                end
            end
            StActive: begin
                // A slave response beats both a master abort and the watchdog.
                if (w_resp) begin
                    w_mdat  = wbs_dat_i;
                    w_ack   = wbs_ack_i;
                    w_err   = wbs_err_i;
                    w_rty   = wbs_rty_i;
                    w_cyc   = 1'b0;
                    w_stb   = 1'b0;
                    w_state = StResp;
                end else if (!wbm_cyc_i) begin
                    w_cyc   = 1'b0;
                    w_stb   = 1'b0;
                    w_state = StIdle;
                end else if (w_wd_hit) begin
                    w_cyc   = 1'b0;
                    w_stb   = 1'b0;
                    w_err   = 1'b1;
                    w_tout  = 1'b1;
                    if (r_tcnt != '1) begin
                        w_tcnt = r_tcnt + CNT_WIDTH'(1);
                    end
                    w_state = StResp;
                end else if (TIMEOUT != 0) begin
                    w_wdog = r_wdog + WD_WIDTH'(1);
                end
            end
            StResp: begin
                w_ack   = 1'b0;
                w_err   = 1'b0;
                w_rty   = 1'b0;
                w_tout  = 1'b0;
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_adr   <= '0;
            r_sdat  <= '0;
            r_mdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_tout  <= 1'b0;
            r_tcnt  <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state;
            r_adr   <= w_adr;
            r_sdat  <= w_sdat;
            r_mdat  <= w_mdat;
            r_sel   <= w_sel;
            r_we    <= w_we;
            r_cyc   <= w_cyc;
            r_stb   <= w_stb;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_rty   <= w_rty;
            r_tout  <= w_tout;
            r_tcnt  <= w_tcnt;
            r_wdog  <= w_wdog;
        end
    end

    assign wbm_dat_o     = r_mdat;
    assign wbm_ack_o     = r_ack;
    assign wbm_err_o     = r_err;
    assign wbm_rty_o     = r_rty;
    assign wbs_adr_o     = r_adr;
    assign wbs_dat_o     = r_sdat;
    assign wbs_we_o      = r_we;
    assign wbs_sel_o     = r_sel;
    assign wbs_stb_o     = r_stb;
    assign wbs_cyc_o     = r_cyc;
    assign timeout_o     = r_tout;
    assign timeout_cnt_o = r_tcnt;

endmodule

// File: tb/tb_wb_timeout_reg.sv
// Directed bench for wb_timeout_reg: one DUT with TIMEOUT=8 and a second with the
// watchdog disabled, sharing the same master and slave stimulus.
module tb_wb_timeout_reg;

    logic        clk;
    logic        rst;
    logic [31:0] wbm_adr_i;
    logic [31:0] wbm_dat_i;
    logic        wbm_we_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_stb_i;
    logic        wbm_cyc_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i;
    logic        wbs_err_i;
    logic        wbs_rty_i;

    logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_we_o, wbs_stb_o, wbs_cyc_o, timeout_o;
    logic [3:0]  wbs_sel_o;
    logic [15:0] timeout_cnt_o;

    logic [31:0] z_wbm_dat_o, z_wbs_adr_o, z_wbs_dat_o;
    logic        z_wbm_ack_o, z_wbm_err_o, z_wbm_rty_o, z_wbs_we_o, z_wbs_stb_o, z_wbs_cyc_o;
    logic        z_timeout_o;
    logic [3:0]  z_wbs_sel_o;
    logic [15:0] z_timeout_cnt_o;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_mdat;

    wb_timeout_reg #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(wbs_cyc_o), .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
    );

    wb_timeout_reg #(.TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(z_wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(z_wbm_ack_o), .wbm_err_o(z_wbm_err_o), .wbm_rty_o(z_wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(z_wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(z_wbs_dat_o),
        .wbs_we_o(z_wbs_we_o), .wbs_sel_o(z_wbs_sel_o), .wbs_stb_o(z_wbs_stb_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(z_wbs_cyc_o), .timeout_o(z_timeout_o), .timeout_cnt_o(z_timeout_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic master_req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        wbs_dat_i = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b required 000000", {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}); end
        n_cmp++; if ({wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, timeout_cnt_o} !== 117'b0) begin n_bad++; $display("FAIL reset_data: got %h required 0", {wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, timeout_cnt_o}); end
        n_cmp++; if ({z_wbm_dat_o, z_wbs_adr_o, z_wbs_dat_o, z_wbm_ack_o, z_wbm_err_o, z_wbm_rty_o, z_wbs_we_o, z_wbs_stb_o, z_wbs_cyc_o, z_timeout_o, z_wbs_sel_o, z_timeout_cnt_o} !== 123'b0) begin n_bad++; $display("FAIL reset_nowd: got nonzero outputs required 0"); end
        rst = 1'b0;
    endtask

    // Zero-wait slave: ack on the first strobe cycle.
    task automatic test_read(input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk); master_req(adr, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 3'b110) begin n_bad++; $display("FAIL read_stb: got %b required 110", {wbs_cyc_o, wbs_stb_o, wbs_we_o}); end
        n_cmp++; if (wbs_adr_o !== adr) begin n_bad++; $display("FAIL read_adr: got %h required %h", wbs_adr_o, adr); end
        n_cmp++; if (wbm_ack_o !== 1'b0) begin n_bad++; $display("FAIL read_early_ack: got %b required 0", wbm_ack_o); end
        wbs_ack_i = 1'b1; wbs_dat_i = dat;
        @(negedge clk);
        exp_mdat = dat;
        n_cmp++; if ({wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 4'b0100) begin n_bad++; $display("FAIL read_resp: got %b required 0100", {wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o}); end
        n_cmp++; if (wbm_dat_o !== exp_mdat) begin n_bad++; $display("FAIL read_data: got %h required %h", wbm_dat_o, exp_mdat); end
        master_idle();
        @(negedge clk);
        n_cmp++; if (wbm_ack_o !== 1'b0) begin n_bad++; $display("FAIL read_ack_len: got %b required 0", wbm_ack_o); end
    endtask

    task automatic test_write_wait();
        int acks = 0;
        @(negedge clk); master_req(32'h40, 32'h1234_5678, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o} !== {3'b111, 4'hF, 32'h40, 32'h1234_5678}) begin n_bad++; $display("FAIL write_hold c%0d: got %b %h %h %h", k, {wbs_cyc_o, wbs_stb_o, wbs_we_o}, wbs_sel_o, wbs_adr_o, wbs_dat_o); end
            acks += int'(wbm_ack_o);
            if (k == 6) begin wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_0001; end
        end
        @(negedge clk);
        acks += int'(wbm_ack_o);
        exp_mdat = 32'hCAFE_0001;
        n_cmp++; if (wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL write_drop: got %b required 0", wbs_cyc_o); end
        master_idle();
        @(negedge clk);
        acks += int'(wbm_ack_o);
        n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL write_ack_count: got %0d required 1", acks); end
    endtask

    task automatic test_timeout(input logic [15:0] exp_cnt);
        @(negedge clk); master_req(32'h200, 32'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++; if ({wbs_cyc_o, timeout_o, wbm_err_o} !== 3'b100) begin n_bad++; $display("FAIL tmo_active c%0d: got %b required 100", k, {wbs_cyc_o, timeout_o, wbm_err_o}); end
        end
        @(negedge clk);
        n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbm_err_o, timeout_o, wbm_ack_o, wbm_rty_o} !== 6'b001100) begin n_bad++; $display("FAIL tmo_fire: got %b required 001100", {wbs_cyc_o, wbs_stb_o, wbm_err_o, timeout_o, wbm_ack_o, wbm_rty_o}); end
        n_cmp++; if (timeout_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL tmo_count: got %0d required %0d", timeout_cnt_o, exp_cnt); end
        n_cmp++; if (wbm_dat_o !== exp_mdat) begin n_bad++; $display("FAIL tmo_dat_hold: got %h required %h", wbm_dat_o, exp_mdat); end
        n_cmp++; if ({z_wbs_cyc_o, z_wbm_err_o, z_timeout_o} !== 3'b100) begin n_bad++; $display("FAIL nowd_waits: got %b required 100", {z_wbs_cyc_o, z_wbm_err_o, z_timeout_o}); end
        master_idle();
        @(negedge clk);
        n_cmp++; if ({wbm_err_o, timeout_o} !== 2'b00) begin n_bad++; $display("FAIL tmo_pulse_len: got %b required 00", {wbm_err_o, timeout_o}); end
        n_cmp++; if ({z_wbs_cyc_o, z_wbm_ack_o, z_wbm_err_o, z_wbm_rty_o} !== 4'b0000) begin n_bad++; $display("FAIL nowd_abort: got %b required 0000", {z_wbs_cyc_o, z_wbm_ack_o, z_wbm_err_o, z_wbm_rty_o}); end
    endtask

    task automatic test_boundary();
        @(negedge clk); master_req(32'h300, 32'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) begin wbs_ack_i = 1'b1; wbs_dat_i = 32'hB0B0_B0B0; end
        end
        @(negedge clk);
        exp_mdat = 32'hB0B0_B0B0;
        n_cmp++; if ({wbm_ack_o, wbm_err_o, timeout_o} !== 3'b100) begin n_bad++; $display("FAIL bound_resp: got %b required 100", {wbm_ack_o, wbm_err_o, timeout_o}); end
        n_cmp++; if (timeout_cnt_o !== 16'd2) begin n_bad++; $display("FAIL bound_count: got %0d required 2", timeout_cnt_o); end
        n_cmp++; if (wbm_dat_o !== exp_mdat) begin n_bad++; $display("FAIL bound_data: got %h required %h", wbm_dat_o, exp_mdat); end
        master_idle();
        @(negedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk); master_req(32'h400, 32'h0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++; if (wbs_cyc_o !== 1'b1) begin n_bad++; $display("FAIL abort_active c%0d: got %b required 1", k, wbs_cyc_o); end
        end
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 5'b0) begin n_bad++; $display("FAIL abort_quiet c%0d: got %b required 00000", k, {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o}); end
        end
    endtask

    task automatic test_retry();
        @(negedge clk); master_req(32'h500, 32'h0, 1'b0);
        @(negedge clk);
        wbs_rty_i = 1'b1; wbs_dat_i = 32'h7777_0000;
        @(negedge clk);
        exp_mdat = 32'h7777_0000;
        n_cmp++; if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b001) begin n_bad++; $display("FAIL retry_flags: got %b required 001", {wbm_ack_o, wbm_err_o, wbm_rty_o}); end
        n_cmp++; if (wbm_dat_o !== exp_mdat) begin n_bad++; $display("FAIL retry_data: got %h required %h", wbm_dat_o, exp_mdat); end
        master_idle();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk); master_req(32'h600, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++; if (wbs_cyc_o !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got %b required 1", wbs_cyc_o); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o} !== 6'b0) begin n_bad++; $display("FAIL arst_bus: got %b required 000000", {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}); end
        n_cmp++; if (timeout_cnt_o !== 16'd0) begin n_bad++; $display("FAIL arst_count: got %0d required 0", timeout_cnt_o); end
        master_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        exp_mdat = 32'h0;
        rst      = 1'b1;
        wbm_adr_i = 32'h0; wbm_dat_i = 32'h0; wbm_we_i = 1'b0; wbm_sel_i = 4'h0;
        master_idle();
        test_reset();
        test_read(32'h100, 32'hDEAD_BEEF);
        test_write_wait();
        test_timeout(16'd1);
        test_timeout(16'd2);
        test_boundary();
        test_abort();
        test_read(32'h104, 32'h5555_AAAA);
        test_retry();
        test_async_reset();
        test_read(32'h108, 32'h0BAD_F00D);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
